mbt_pixel_packer: RTL
=====================

Name: mbt_pixel_packer

Overview:
- Sits between the Mandelbrot iteration engine and the dual-port frame BRAM write port (port A, system clock domain).
- Accepts one 8-bit iteration count per pixel over a valid/ready handshake in raster order.
- Packs four pixels into one 32-bit word and issues one BRAM write per word, with byte enables and a word address.
- Flushes a partial trailing word, signals frame completion, and restarts cleanly on a new frame request.

Parameters:
- H_RES, 800, active pixels per line.
- V_RES, 600, active lines per frame.
- ADDR_W, 17, word-address width; must satisfy 2^ADDR_W >= ceil(H_RES*V_RES/4).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset, asynchronous, active-high.
- i_frame_start  in  1  one-cycle pulse; begin (or restart) a frame at word 0.
- i_valid  in  1  pixel valid from engine.
- i_data  in  8  pixel iteration count.
- o_ready  out  1  packer accepts a pixel this cycle.
- o_wea  out  4  BRAM byte write enables; bit k enables o_dout[8k+7:8k].
- o_addr  out  ADDR_W  BRAM word address.
- o_dout  out  32  BRAM write data.
- o_busy  out  1  frame in progress.
- o_frame_done  out  1  one-cycle pulse after the last write of a frame.

Behaviour:
- Reset values: o_ready=0, o_wea=0, o_addr=0, o_dout=0, o_busy=0, o_frame_done=0. Internally, state=IDLE and all counters and the shift register are 0.
- States:
  - IDLE: entered from reset or DONE. Goes to RUN on i_frame_start.
  - RUN: goes to DONE after the last pixel's write has been issued. Goes back to RUN with counters cleared on i_frame_start.
  - DONE: lasts one cycle, then goes to IDLE.
- o_ready=1 only in RUN, and is registered. It deasserts the cycle after the final pixel (H_RES*V_RES) is accepted.
- A transfer happens when i_valid & o_ready. i_data is ignored when there is no transfer.
- Pixel counter pix_cnt: width ceil(log2(H_RES*V_RES+1)), counts accepted pixels from 0.
- Byte lane = pix_cnt[1:0]. Pixel p lands in lane p mod 4 of word p/4; lane 0 is o_dout[7:0], matching the read side's 8-bit little-endian port.
- Full-word write:
  - Triggered when a transfer fills lane 3.
  - The next cycle drives o_wea=4'b1111, o_addr = word index, o_dout = packed word.
  - Latency from accepting the 4th pixel to the strobe is exactly 1 cycle.
  - o_wea is high for exactly one cycle per write.
  - Acceptance continues without a bubble (sustained 1 pixel/cycle).
- Non-write cycles: o_wea=0, while o_addr and o_dout hold their last values.
- Partial trailing word: used when H_RES*V_RES mod 4 != 0. The cycle after the last pixel is accepted, write with o_wea enabling only the filled lanes (e.g. 2 pixels gives 4'b0011). Unfilled lanes of o_dout are 0.
- o_frame_done: pulses in the same cycle as the final write strobe; o_busy drops on that same cycle.
  - 800x600 gives 480000 pixels, 120000 writes, last o_addr=119999.
- o_busy=1 in RUN and 0 in IDLE and DONE.
- i_frame_start has priority over a simultaneous transfer:
  - The pixel is not accepted and the partially filled word is discarded (no write).
  - Any write strobe already scheduled from the previous cycle still completes.
  - The next cycle is RUN with pix_cnt=0 and o_ready=1, with no o_frame_done for the aborted frame.
- i_frame_start in DONE is honoured: enter RUN next cycle.
- Word index never exceeds ceil(H_RES*V_RES/4)-1, so there is no wrap-around.
- Asynchronous rst mid-frame forces all reset values immediately; no write completes after rst asserts.

Decomposition:
- Shared package holds:
  - PIX_W=8, BYTES_PER_WORD=4, WORD_W=32.
  - The state encoding typedef (IDLE, RUN, DONE).
  - A function for words-per-frame = ceil(H_RES*V_RES/4).
- One natural sub-module: mbt_byte_lane_packer. It holds the 4-byte shift/merge register, lane counter and lane-mask generation, with load/flush/clear controls. The FSM, pixel counter and address counter stay in the top.

Test Plan:
- Reset then frame_start, stream pixels 0x00..0x07 with i_valid held high -> o_wea=4'b1111 at addr 0 with dout 0x03020100 one cycle after the 4th accept, then addr 1 with dout 0x07060504; o_ready never drops.
- Full 800x600 frame with random valid gaps -> exactly 120000 strobes at addresses 0..119999, in order with no repeats; o_frame_done pulses once, coincident with the addr 119999 write; o_ready=0 afterwards.
- H_RES=3, V_RES=2 (6 pixels 0xA0..0xA5) -> writes addr 0 dout 0xA3A2A1A0 wea 1111, then addr 1 dout 0x0000A5A4 wea 0011 together with o_frame_done.
- frame_start asserted with i_valid after 6 pixels accepted -> word 0 written, lanes of word 1 discarded, no frame_done; next accepted pixel lands at addr 0 lane 0.
- rst pulsed one cycle before a scheduled write -> o_wea stays 0, all outputs at reset values, o_ready=0 until the next frame_start.
- Pixels with i_valid=1 in IDLE (no frame_start) -> o_ready=0, no writes, o_busy=0.

Source files
------------

// File: rtl/mbt_pixel_packer_pkg.sv
// Shared constants, state encoding and frame-size helper for the pixel packer.
package mbt_pixel_packer_pkg;

  localparam int PIX_W          = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int words_per_frame(input int h_res, input int v_res);
    return (h_res * v_res + BYTES_PER_WORD - 1) / BYTES_PER_WORD;
  endfunction

endpackage

// File: rtl/mbt_byte_lane_packer.sv
// Four-lane byte merge register: lane 0 is the low byte, lanes fill in order.
module mbt_byte_lane_packer
  import mbt_pixel_packer_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clear,
  input  logic                      i_load,
  input  logic                      i_flush,
  input  logic [PIX_W-1:0]          i_data,
  output logic [WORD_W-1:0]         o_word,
  output logic [BYTES_PER_WORD-1:0] o_mask,
  output logic                      o_full
);

  logic [WORD_W-1:0] r_word;
  logic [1:0]        r_lane;

  // o_word/o_mask already include the incoming byte so the emit can be registered on the same edge
  always_comb begin
    o_word = r_word;
    o_word[r_lane*PIX_W +: PIX_W] = i_data;
    case (r_lane)
      2'd0:    o_mask = 4'b0001;
      2'd1:    o_mask = 4'b0011;
      2'd2:    o_mask = 4'b0111;
      default: o_mask = 4'b1111;
    endcase
  end

  assign o_full = i_load & (r_lane == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_lane <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_lane <= '0;
    end else if (i_load) begin
      if (o_full || i_flush) begin
        r_word <= '0;
        r_lane <= '0;
      end else begin
        r_word <= o_word;
        r_lane <= r_lane + 2'd1;
      end
    end
  end

endmodule

// File: rtl/mbt_pixel_packer.sv
// Packs 8-bit iteration counts four to a word and issues frame BRAM writes.
//   state   | meaning
//   IDLE    | waiting for i_frame_start, not accepting pixels
//   RUN     | accepting pixels, issuing one write per packed word
//   DONE    | final write and frame_done pulse are on the outputs
module mbt_pixel_packer
  import mbt_pixel_packer_pkg::*;
#(
  parameter int H_RES  = 800,
  parameter int V_RES  = 600,
  parameter int ADDR_W = 17
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_frame_start,
  input  logic                      i_valid,
  input  logic [PIX_W-1:0]          i_data,
  output logic                      o_ready,
  output logic [BYTES_PER_WORD-1:0] o_wea,
  output logic [ADDR_W-1:0]         o_addr,
  output logic [WORD_W-1:0]         o_dout,
  output logic                      o_busy,
  output logic                      o_frame_done
);

  localparam int N_PIX   = H_RES * V_RES;
  localparam int CNT_W   = $clog2(N_PIX + 1);
  localparam int N_WORDS = words_per_frame(H_RES, V_RES);
  localparam logic [CNT_W-1:0]  LAST_PIX  = CNT_W'(N_PIX - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

  state_t                    r_state;
  logic [CNT_W-1:0]          r_pix_cnt;
  logic [ADDR_W-1:0]         r_word_idx;
  logic                      w_xfer;
  logic                      w_last;
  logic                      w_full;
  logic [WORD_W-1:0]         w_word;
  logic [BYTES_PER_WORD-1:0] w_mask;

  // a frame restart wins over a simultaneous pixel, which is dropped
  assign w_xfer = i_valid & o_ready & ~i_frame_start;
  assign w_last = w_xfer & (r_pix_cnt == LAST_PIX);

  mbt_byte_lane_packer u_lanes (
    .clk     (clk),
    .rst     (rst),
    .i_clear (i_frame_start),
    .i_load  (w_xfer),
    .i_flush (w_last),
    .i_data  (i_data),
    .o_word  (w_word),
    .o_mask  (w_mask),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_pix_cnt    <= '0;
      r_word_idx   <= '0;
      o_ready      <= 1'b0;
      o_wea        <= '0;
      o_addr       <= '0;
      o_dout       <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_wea        <= '0;
      o_frame_done <= 1'b0;
      if (i_frame_start) begin
        r_state    <= ST_RUN;
        r_pix_cnt  <= '0;
        r_word_idx <= '0;
        o_ready    <= 1'b1;
        o_busy     <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: ;
          ST_RUN: begin
            if (w_xfer) begin
              r_pix_cnt <= r_pix_cnt + CNT_W'(1);
              if (w_full || w_last) begin
                o_wea  <= w_mask;
                o_addr <= r_word_idx;
                o_dout <= w_word;
                if (r_word_idx != LAST_ADDR) r_word_idx <= r_word_idx + ADDR_W'(1);
              end
              if (w_last) begin
                r_state      <= ST_DONE;
                o_ready      <= 1'b0;
                o_busy       <= 1'b0;
                o_frame_done <= 1'b1;
              end
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: begin
            r_state <= ST_IDLE;
            o_ready <= 1'b0;
            o_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
